// File: rtl/biriscv_fetch_ctrl.sv
// Fetch-PC sequencer: owns the fetch PC, issues 64-bit icache requests, drops stale responses
// and buffers responses toward decode. Define BIRISCV_FETCH_DUAL_BUF_EN for a two-entry pipeline.
module biriscv_fetch_ctrl #(
  parameter logic [31:0] BOOT_VECTOR = 32'h80000000
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        branch_request_i,
  input  logic [31:0] branch_pc_i,
  input  logic [31:0] next_pc_f_i,
  input  logic [1:0]  next_taken_f_i,
  output logic [31:0] pc_f_o,
  output logic        pc_accept_o,
  output logic        icache_rd_o,
  output logic [31:0] icache_pc_o,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic [63:0] icache_inst_i,
  input  logic        icache_error_i,
  output logic        fetch_valid_o,
  output logic [63:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic [1:0]  fetch_pred_o,
  output logic        fetch_fault_o,
  input  logic        fetch_accept_i
);
`ifdef BIRISCV_FETCH_DUAL_BUF_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif
  localparam logic [2:0] DEPTH = 3'(D);

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  pred;
  } tag_t;

  typedef struct packed {
    logic [63:0] inst;
    logic [31:0] pc;
    logic [1:0]  pred;
    logic        fault;
  } ent_t;

  logic [31:0]       pc_q, pc_d;
  logic [1:0]        out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
  logic              halt_q, halt_d, run_q, run_d;
  tag_t [D-1:0]      tag_q, tag_d;
  ent_t [D-1:0]      buf_q, buf_d;
  logic              resp_vld, push, pop;
  logic [1:0]        tag_wr, buf_wr;

  always_comb begin
    // responses with no tag entry (e.g. after reset) are ignored
    resp_vld    = icache_valid_i & (out_q != 2'd0);
    icache_rd_o = run_q & ~halt_q & ~branch_request_i & ((3'(cnt_q) + 3'(out_q)) < DEPTH);
    pc_accept_o = icache_rd_o & icache_accept_i;
    push        = resp_vld & (drop_q == 2'd0) & ~branch_request_i;
    pop         = (cnt_q != 2'd0) & fetch_accept_i & ~branch_request_i;
    run_d       = 1'b1;

    tag_d = tag_q;
    if (resp_vld)
      for (int i = 0; i < D - 1; i++) tag_d[i] = tag_q[i+1];
    tag_wr = out_q - {1'b0, resp_vld};
    if (pc_accept_o)
      for (int i = 0; i < D; i++)
        if (int'(tag_wr) == i) tag_d[i] = {pc_q, next_taken_f_i};
    out_d = out_q + {1'b0, pc_accept_o} - {1'b0, resp_vld};

    buf_d = buf_q;
    if (pop)
      for (int i = 0; i < D - 1; i++) buf_d[i] = buf_q[i+1];
    buf_wr = cnt_q - {1'b0, pop};
    if (push)
      for (int i = 0; i < D; i++)
        if (int'(buf_wr) == i) buf_d[i] = {icache_inst_i, tag_q[0].pc, tag_q[0].pred, icache_error_i};
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

    pc_d   = pc_q;
    drop_d = drop_q;
    halt_d = halt_q | (push & icache_error_i);
    if (pc_accept_o) pc_d = next_pc_f_i;
    if (resp_vld && drop_q != 2'd0) drop_d = drop_q - 2'd1;

    // redirect wins over everything; every request still in flight becomes stale
    if (branch_request_i) begin
      pc_d   = branch_pc_i;
      cnt_d  = 2'd0;
      drop_d = out_q - {1'b0, resp_vld};
      halt_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= BOOT_VECTOR;
      out_q  <= '0;
      drop_q <= '0;
      cnt_q  <= '0;
      halt_q <= 1'b0;
      run_q  <= 1'b0;
      tag_q  <= '0;
      buf_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
      halt_q <= halt_d;
      run_q  <= run_d;
      tag_q  <= tag_d;
      buf_q  <= buf_d;
    end
  end

  assign pc_f_o        = pc_q;
  assign icache_pc_o   = {pc_q[31:3], 3'b000};
  assign fetch_valid_o = (cnt_q != 2'd0);
  assign fetch_instr_o = buf_q[0].inst;
  assign fetch_pc_o    = buf_q[0].pc;
  assign fetch_pred_o  = buf_q[0].pred;
  assign fetch_fault_o = fetch_valid_o & buf_q[0].fault;
endmodule

// File: tb/tb_biriscv_fetch_ctrl.sv
// Randomized bench for biriscv_fetch_ctrl: a transaction-level model of in-flight requests and
// the decode-side buffer predicts every request and every entry delivered to decode.
module tb_biriscv_fetch_ctrl;
`ifdef BIRISCV_FETCH_DUAL_BUF_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif
  localparam logic [31:0] BOOT = 32'h80000000;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        branch_request_i;
  logic [31:0] branch_pc_i;
  logic [31:0] next_pc_f_i;
  logic [1:0]  next_taken_f_i;
  logic [31:0] pc_f_o;
  logic        pc_accept_o;
  logic        icache_rd_o;
  logic [31:0] icache_pc_o;
  logic        icache_accept_i;
  logic        icache_valid_i;
  logic [63:0] icache_inst_i;
  logic        icache_error_i;
  logic        fetch_valid_o;
  logic [63:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic [1:0]  fetch_pred_o;
  logic        fetch_fault_o;
  logic        fetch_accept_i;

  biriscv_fetch_ctrl #(.BOOT_VECTOR(BOOT)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .branch_request_i(branch_request_i), .branch_pc_i(branch_pc_i),
    .next_pc_f_i(next_pc_f_i), .next_taken_f_i(next_taken_f_i),
    .pc_f_o(pc_f_o), .pc_accept_o(pc_accept_o),
    .icache_rd_o(icache_rd_o), .icache_pc_o(icache_pc_o), .icache_accept_i(icache_accept_i),
    .icache_valid_i(icache_valid_i), .icache_inst_i(icache_inst_i), .icache_error_i(icache_error_i),
    .fetch_valid_o(fetch_valid_o), .fetch_instr_o(fetch_instr_o), .fetch_pc_o(fetch_pc_o),
    .fetch_pred_o(fetch_pred_o), .fetch_fault_o(fetch_fault_o), .fetch_accept_i(fetch_accept_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  pred;
    logic        stale;
  } req_t;

  typedef struct {
    logic [63:0] inst;
    logic [31:0] pc;
    logic [1:0]  pred;
    logic        fault;
  } exp_t;

  req_t        oq[$];   // requests the cache has accepted but not answered
  exp_t        eq[$];   // entries decode should see, in order
  logic [31:0] mpc;
  logic        mhalt;
  logic        active = 1'b0;
  int          pass_cnt = 0;
  int          tot_cnt = 0;
  int          pops = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc_f"}, 64'(pc_f_o), 64'(BOOT));
    chk({tag, "_rd"}, 64'(icache_rd_o), 64'd0);
    chk({tag, "_pc_accept"}, 64'(pc_accept_o), 64'd0);
    chk({tag, "_fetch_valid"}, 64'(fetch_valid_o), 64'd0);
    chk({tag, "_fetch_fault"}, 64'(fetch_fault_o), 64'd0);
    chk({tag, "_fetch_instr"}, fetch_instr_o, 64'd0);
    chk({tag, "_fetch_pc"}, 64'(fetch_pc_o), 64'd0);
    chk({tag, "_fetch_pred"}, 64'(fetch_pred_o), 64'd0);
  endtask

  task automatic idle_inputs();
    branch_request_i = 1'b0; branch_pc_i = '0;
    next_pc_f_i = '0;        next_taken_f_i = '0;
    icache_accept_i = 1'b0;  icache_valid_i = 1'b0;
    icache_inst_i = '0;      icache_error_i = 1'b0;
    fetch_accept_i = 1'b0;
  endtask

  // Driver: picks this cycle's inputs, checks the request side, then advances the model at the edge.
  initial begin : driver
    int   stall;
    logic br, acc, resp, err, exp_rd;
    logic [31:0] bpc, npc, apc;
    logic [1:0]  pred;
    logic [63:0] inst;
    req_t t;
    stall = 0;
    forever begin
      @(negedge clk_i);
      if (active) begin
        br   = mhalt ? ($urandom_range(3) == 0) : ($urandom_range(29) == 0);
        bpc  = {16'h8000, 14'($urandom), 2'b00};
        npc  = ($urandom_range(7) == 0) ? {16'h8000, 14'($urandom), 2'b00} : mpc + 32'd8;
        pred = 2'($urandom);
        acc  = ($urandom_range(3) != 0);
        resp = (oq.size() != 0) && ($urandom_range(1) == 1);
        err  = resp && ($urandom_range(15) == 0);
        inst = {$urandom, $urandom};
        branch_request_i = br;   branch_pc_i = bpc;
        next_pc_f_i = npc;       next_taken_f_i = pred;
        icache_accept_i = acc;   icache_valid_i = resp;
        icache_inst_i = inst;    icache_error_i = err;
        if (stall > 0) begin
          stall--;
          fetch_accept_i = 1'b0;
        end else begin
          if ($urandom_range(31) == 0) stall = 10;
          fetch_accept_i = ($urandom_range(3) != 0);
        end
        #1;
        exp_rd = !mhalt && !br && ((eq.size() + oq.size()) < D);
        apc = mpc;
        apc[2:0] = 3'b000;
        chk("icache_rd", 64'(icache_rd_o), 64'(exp_rd));
        chk("pc_f", 64'(pc_f_o), 64'(mpc));
        chk("pc_accept", 64'(pc_accept_o), 64'(exp_rd && acc));
        if (exp_rd) chk("icache_pc", 64'(icache_pc_o), 64'(apc));
        @(posedge clk_i);
        if (resp) begin
          t = oq.pop_front();
          if (!t.stale && !br) begin
            eq.push_back('{inst: inst, pc: t.pc, pred: t.pred, fault: err});
            if (err) mhalt = 1'b1;
          end
        end
        if (br) begin
          foreach (oq[i]) oq[i].stale = 1'b1;
          eq.delete();
          mhalt = 1'b0;
          mpc = bpc;
        end else if (exp_rd && acc) begin
          oq.push_back('{pc: mpc, pred: pred, stale: 1'b0});
          mpc = npc;
        end
      end
    end
  end

  // Monitor: checks the decode side and retires scoreboard entries on each handshake.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (active) begin
        chk("fetch_valid", 64'(fetch_valid_o), 64'(eq.size() != 0));
        if (fetch_valid_o && fetch_accept_i && !branch_request_i && eq.size() != 0) begin
          e = eq.pop_front();
          pops++;
          chk("fetch_instr", fetch_instr_o, e.inst);
          chk("fetch_pc", 64'(fetch_pc_o), 64'(e.pc));
          chk("fetch_pred", 64'(fetch_pred_o), 64'(e.pred));
          chk("fetch_fault", 64'(fetch_fault_o), 64'(e.fault));
        end
      end
    end
  end

  initial begin : main
    rst_n = 1'b0;
    idle_inputs();
    mpc = BOOT;
    mhalt = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    #1;
    chk("rd_before_first_edge", 64'(icache_rd_o), 64'd0);
    @(posedge clk_i);
    #3;
    active = 1'b1;
    repeat (4000) @(posedge clk_i);
    #3;
    active = 1'b0;
    chk("progress", 64'(pops > 100), 64'd1);

    // reset in the middle of traffic, then a late response with no request behind it
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    oq.delete();
    eq.delete();
    @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);
    icache_valid_i = 1'b1;
    icache_inst_i  = 64'hdead_beef_cafe_f00d;
    @(negedge clk_i);
    icache_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("late_resp_no_valid", 64'(fetch_valid_o), 64'd0);
      @(negedge clk_i);
    end
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
